band_sample_queue: RTL
======================

// Module: band_sample_queue
// PURPOSE
//  Circular sample queue that buffers the incoming 16-bit signed audio stream for one equalizer band.
//  Each new sample replays the most recent WIN samples, oldest first, one per clock.
//  Replay is a burst with sequencing asserted, feeding the band FIR core directly.
//  The FIR core restarts its coefficient pointer on sequencing rise and accumulates while it is high.
// PARAMETERS
//  DW     16    sample width (signed, two's complement)
//  WIN    1021  samples per replay burst = FIR tap count; WIN >= 2
//  DEPTH  1536  storage entries; DEPTH > WIN; pointers wrap DEPTH-1 -> 0
// PORTS
//  clk         in   1   system clock; all state changes on rising edge
//  rst         in   1   asynchronous, active-high reset
//  wrt_smpl    in   1   one-cycle strobe: smpl_in valid, push it
//  smpl_in     in   DW  signed input sample
//  sequencing  out  1   high while smpl_out carries a replay sample
//  smpl_out    out  DW  signed replayed sample (registered)
//  overrun     out  1   sticky overrun flag (only with QUEUE_OVERRUN_DET_EN)
// BEHAVIOUR
//  Reset (async, immediate): new_ptr=0, old_ptr=0, rd_ptr=0, fill count=0, state=IDLE,
//   sequencing=0, smpl_out=0, overrun=0. Memory contents are not cleared; fill count alone marks validity.
//  Storage: DEPTH x DW RAM, one write port, one synchronous read port (1-cycle read latency).
//  Push (wrt_smpl=1 at edge T, state IDLE):
//   - Write: mem[new_ptr]<=smpl_in; new_ptr<=new_ptr+1 (wrap).
//   - Count < WIN: count<=count+1.
//   - Count == WIN: old_ptr<=old_ptr+1 (wrap); oldest sample dropped.
//   - Post-write count == WIN: replay starts. The first replay occurs on the WIN-th sample after reset.
//  FSM IDLE -> READ on replay start:
//   - rd_ptr<=oldest valid entry after the push (post-update old_ptr); rd_cnt<=0.
//  READ state:
//   - Issue one read per cycle; rd_ptr increments with wrap, rd_cnt increments.
//   - Return to IDLE after WIN reads.
//  Output timing:
//   - smpl_out/sequencing registered from RAM dout.
//   - sequencing=1 for exactly WIN consecutive cycles, from edge T+1 through edge T+WIN; 0 after edge T+WIN+1.
//   - smpl_out order: oldest ... newest; the last value equals the sample pushed at T.
//   - smpl_out holds its last value while sequencing=0.
//  Write/read overlap: the write slot is never inside the window being read, since DEPTH > WIN.
//   Same-cycle write and read at different addresses is legal.
//  wrt_smpl during READ:
//   - Sample is written and pointers/count updated exactly as in IDLE.
//   - The running burst continues unchanged; no restart; no replay is queued for that sample.
//  Reset mid-burst: outputs drop to 0 at once. The next replay requires WIN fresh pushes.
//  Arithmetic: data is passed through bit-exact; no scaling or saturation. Pointer width is $clog2(DEPTH).
// CONFIGURATION
//  QUEUE_OVERRUN_DET_EN defined:
//   - overrun port present.
//   - Set to 1 on any wrt_smpl seen while state=READ; held until rst.
//  QUEUE_OVERRUN_DET_EN undefined:
//   - overrun port and its logic are absent.
//   - Datapath behaviour is identical.
// TESTING  (bench params DW=16, WIN=5, DEPTH=8)
//  1. Reset, push 1,2,3,4 -> sequencing never asserts; smpl_out stays 0.
//  2. Push 5 -> sequencing high for exactly 5 cycles starting next edge; smpl_out=1,2,3,4,5; then sequencing=0, smpl_out holds 5.
//  3. Push 6..10 one at a time, each after its burst ends -> bursts 2..6, 3..7, ... ,6..10. new_ptr wraps 7->0; last burst reads across the wrap.
//  4. Push 11, then wrt_smpl (value 12) two cycles later -> burst 7..11 completes unchanged; no burst for 12. Next push 13 -> burst 9,10,11,12,13. overrun=1 with QUEUE_OVERRUN_DET_EN.
//  5. Assert rst on 3rd cycle of a burst -> sequencing=0, smpl_out=0 same cycle; pushes 1..4 produce no burst; 5th push replays 1..5.
//  6. Push -32768, 32767, -1 in the window -> same bit patterns appear on smpl_out (0x8000, 0x7FFF, 0xFFFF).

Source files
------------

// File: rtl/band_sample_queue.sv
// band_sample_queue
//   Circular sample queue for one equalizer band. Every pushed sample is
//   stored. Once WIN samples are held, each push replays the most recent WIN
//   samples, oldest first, one per clock. The replay goes straight to the band
//   FIR core, which restarts on the rising edge of sequencing and accumulates
//   while sequencing is high.
//
// Parameters
//   DW     sample width (signed, two's complement)
//   WIN    samples per replay burst (FIR tap count), WIN >= 2
//   DEPTH  storage entries, DEPTH > WIN
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   wrt_smpl    one-cycle strobe: smpl_in is valid and is pushed
//   smpl_in     input sample
//   sequencing  high while smpl_out carries a replay sample
//   smpl_out    replayed sample (registered, holds while sequencing=0)
//   overrun     sticky: a push arrived during a replay burst
//               (present only when QUEUE_OVERRUN_DET_EN is defined)
//
// Handshake: there is no backpressure. wrt_smpl is a fire-and-forget strobe,
// and sequencing qualifies smpl_out on every cycle it is high. The consumer
// must take a sample on every such cycle.
//
// Optional feature macro: QUEUE_OVERRUN_DET_EN

module band_sample_queue #(
  parameter int DW    = 16,
  parameter int WIN   = 1021,
  parameter int DEPTH = 1536
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wrt_smpl,
  input  logic [DW-1:0] smpl_in,
  output logic          sequencing,
  output logic [DW-1:0] smpl_out
`ifdef QUEUE_OVERRUN_DET_EN
  ,
  output logic          overrun
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(WIN + 1);

  typedef enum logic {IDLE, READ} state_t;

  state_t        state;
  logic [AW-1:0] new_ptr;
  logic [AW-1:0] old_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] fill_cnt;
  logic [CW-1:0] rd_cnt;

  logic [DW-1:0] mem [DEPTH];

  logic [AW-1:0] old_ptr_nxt;
  logic [CW-1:0] fill_cnt_nxt;
  logic          full;
  logic          replay_start;

  function automatic logic [AW-1:0] inc_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Once full, every push drops the oldest entry. The replay window always
  // begins at the oldest entry as it stands after the push.
  always_comb begin
    full         = (fill_cnt == CW'(WIN));
    old_ptr_nxt  = old_ptr;
    fill_cnt_nxt = fill_cnt;
    if (wrt_smpl) begin
      if (full) old_ptr_nxt  = inc_ptr(old_ptr);
      else      fill_cnt_nxt = fill_cnt + CW'(1);
    end
    // A push during READ never restarts or queues a burst.
    replay_start = wrt_smpl && (fill_cnt_nxt == CW'(WIN)) && (state == IDLE);
  end

  // Write port. Contents are deliberately not reset; fill_cnt alone marks
  // which entries are valid.
  always_ff @(posedge clk) begin
    if (wrt_smpl) mem[new_ptr] <= smpl_in;
  end

  // Control FSM and synchronous read port. The read register is smpl_out
  // itself, so a read issued in READ appears on the output one edge later.
  // A write to the newest slot at the push edge is therefore visible to the
  // final read of the burst. The write slot never falls inside the window
  // being read, because DEPTH > WIN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      new_ptr    <= '0;
      old_ptr    <= '0;
      rd_ptr     <= '0;
      fill_cnt   <= '0;
      rd_cnt     <= '0;
      sequencing <= 1'b0;
      smpl_out   <= '0;
    end else begin
      if (wrt_smpl) new_ptr <= inc_ptr(new_ptr);
      old_ptr  <= old_ptr_nxt;
      fill_cnt <= fill_cnt_nxt;

      sequencing <= (state == READ);

      case (state)
        IDLE: begin
          if (replay_start) begin
            state  <= READ;
            rd_ptr <= old_ptr_nxt;
            rd_cnt <= '0;
          end
        end
        READ: begin
          smpl_out <= mem[rd_ptr];
          rd_ptr   <= inc_ptr(rd_ptr);
          rd_cnt   <= rd_cnt + CW'(1);
          if (rd_cnt == CW'(WIN - 1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef QUEUE_OVERRUN_DET_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            overrun <= 1'b0;
    else if (wrt_smpl && state == READ) overrun <= 1'b1;
  end
`endif

endmodule
